useq_gen: RTL and testbench
===========================

Name: useq_gen

Overview:
- Parametrised microprogram sequencer; next generation of the fixed 8-bit-address micro control unit.
- Owns the micro-PC, the microinstruction register (uir) and a return-address stack.
- Computes next_upc for the microcode ROM. The ROM samples its address on the falling clk edge and returns the word before the next rising edge.
- Adds features the current sequencer lacks: conditional branch on regalu flags, opcode dispatch, micro-subroutine call/return, memory wait, external hold, halt.

Parameters:
- UA, 8: micro-address width.
- UW, 24: microword width.
- NFLAG, 4: flag inputs, max 4.
- SDEPTH, 4: return-stack entries, ≥1.
- OPW, 4: dispatch opcode width, ≤ UA.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- rom_d  in  UW  microword addressed by the previous next_upc.
- flags  in  NFLAG  ALU flags, combinational from regalu.
- opcode  in  OPW  macro-opcode from alu_ir, used by DISP.
- mem_ready  in  1  RAM handshake, used by WAIT.
- hold  in  1  external freeze request.
- next_upc  out  UA  ROM address, combinational.
- upc  out  UA  address of the word currently in uir.
- uir  out  UW  current microinstruction; regalu/ram controls are decoded from it outside this block.
- depth  out  clog2(SDEPTH+1)  stack occupancy.
- halted  out  1  sequencer frozen by HALT or error.
- stack_err  out  1  sticky stack overflow/underflow.

Behaviour:
- Microword fields:
  - seq_op = uir[UW-1:UW-3].
  - cond = uir[UW-4:UW-6], split as {pol, sel[1:0]}.
  - target = uir[UA-1:0]; this field overlays imm8.
  - An all-zero word is NOP/NEXT.
- Reset (rst high at a clk edge):
  - upc <= all ones, uir <= 0, depth <= 0, stack_err <= 0.
  - next_upc is 0 while rst is high.
  - After release, first next_upc = upc+1, which wraps to 0. Word 0 is therefore the first executed.
  - Reset mid-call discards the stack.
- Every rising edge (not in reset): uir <= rom_d, upc <= next_upc. One microinstruction per cycle.
- next_upc priority, highest first:
  1. rst: 0.
  2. stack_err or seq_op=HALT: upc.
  3. hold: upc, no stack change.
  4. seq_op decode, below.
- seq_op decode (all +1 arithmetic is modulo 2^UA):
  - 0 NEXT: upc+1.
  - 1 JMP: target.
  - 2 JCOND: target if flags[sel]==pol, else upc+1. sel ≥ NFLAG reads 0.
  - 3 CALL: push upc+1, go to target. If depth==SDEPTH: no push, stack_err<=1, next_upc=upc.
  - 4 RET: pop, go to popped address. If depth==0: stack_err<=1, next_upc=upc.
  - 5 DISP: target + zero-extended opcode, wrapping.
  - 6 WAIT: upc+1 if mem_ready, else upc.
  - 7 HALT: upc.
- Re-fetch: when next_upc==upc, the ROM refetches the same word, so uir is effectively unchanged. Stack is never modified on a held, halted or waiting cycle.
- halted = stack_err | (seq_op==HALT). Leaves HALT only through reset.
- stack_err is sticky until rst.
- depth updates on the same edge as upc. CALL then RET back-to-back is legal.

Decomposition:
- Package useq_pkg:
  - seq_op enum: SEQ_NEXT, SEQ_JMP, SEQ_JCOND, SEQ_CALL, SEQ_RET, SEQ_DISP, SEQ_WAIT, SEQ_HALT.
  - Field offset functions of UW/UA.
- Sub-module useq_stack: LIFO, SDEPTH×UA.
  - Inputs: push, pop, din.
  - Outputs: top, depth, full, empty.
  - Synchronous rst.
  - Push when full and pop when empty are ignored; the parent flags the error.

Test Plan:
- Reset: rst high 2 cycles → next_upc=0, upc=0xFF. After release, ROM all NEXT → next_upc sequence 0,1,2,3; upc lags next_upc by one cycle.
- JCOND: word at 0x05 = JCOND sel=1 pol=1 target=0x40. flags=4'b0010 → next_upc=0x40. flags=0 → 0x06. pol=0 with flags=0 → 0x40.
- CALL/RET:
  - Program: 0x10 CALL 0x80; 0x80 CALL 0x90; 0x90 RET; 0x81 RET.
  - Expected upc trace: 0x10, 0x80, 0x90, 0x81, 0x11.
  - Expected depth: 0, 1, 2, 1, 0.
- Overflow (SDEPTH=4): five nested CALLs → fifth raises stack_err and halted; depth stays 4; next_upc frozen at the fifth CALL address. Separately, RET at depth 0 → stack_err=1.
- DISP: target=0x30, opcode=0xA → next_upc=0x3A. target=0xF8, opcode=0xA → 0x02 (wrap).
- WAIT/hold:
  - WAIT at 0x20 with mem_ready low 3 cycles → upc=0x20 for 4 cycles; then 0x21 after mem_ready rises.
  - hold=1 across JMP 0x50 → upc frozen; jumps to 0x50 the cycle after hold drops.

Source files
------------

// File: rtl/useq_pkg.sv
// Shared definitions for the microprogram sequencer: sequencing opcodes and
// microword field positions expressed as functions of the word widths.
package useq_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_JMP   = 3'd1,
    SEQ_JCOND = 3'd2,
    SEQ_CALL  = 3'd3,
    SEQ_RET   = 3'd4,
    SEQ_DISP  = 3'd5,
    SEQ_WAIT  = 3'd6,
    SEQ_HALT  = 3'd7
  } seq_op_e;

  localparam int SEQ_OP_W = 3;
  localparam int COND_W   = 3;

  // seq_op occupies the top three bits, cond the three just below it.
  function automatic int seqOpLsb(input int uw);
    return uw - SEQ_OP_W;
  endfunction

  function automatic int condLsb(input int uw);
    return uw - SEQ_OP_W - COND_W;
  endfunction

  function automatic int targetMsb(input int ua);
    return ua - 1;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address LIFO for micro-subroutine calls. Overflowing pushes and
// underflowing pops are silently dropped; the sequencer reports them.
module useq_stack #(
  parameter int UA     = 8,
  parameter int SDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [UA-1:0]                 din_i,
  output logic [UA-1:0]                 top_o,
  output logic [$clog2(SDEPTH+1)-1:0]   depth_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int DW = $clog2(SDEPTH + 1);
  localparam int AW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [UA-1:0] mem_q [SDEPTH];
  logic [DW-1:0] depth_q;
  logic          doPush;
  logic          doPop;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  assign full_o  = (depth_q == DW'(SDEPTH));
  assign empty_o = (depth_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign wrPtr   = AW'(depth_q);
  assign rdPtr   = AW'(depth_q - DW'(1));
  assign top_o   = empty_o ? '0 : mem_q[rdPtr];
  assign depth_o = depth_q;

  // Entry contents need no reset: only slots below depth_q are ever read.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (doPush) begin
      mem_q[wrPtr] <= din_i;
      depth_q      <= depth_q + DW'(1);
    end else if (doPop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/useq_gen.sv
// Microprogram sequencer: holds micro-PC and microinstruction register and
// computes the next ROM address from the sequencing field of the current word.
module useq_gen
  import useq_pkg::*;
#(
  parameter int UA     = 8,
  parameter int UW     = 24,
  parameter int NFLAG  = 4,
  parameter int SDEPTH = 4,
  parameter int OPW    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [UW-1:0]               rom_d,
  input  logic [NFLAG-1:0]            flags,
  input  logic [OPW-1:0]              opcode,
  input  logic                        mem_ready,
  input  logic                        hold,
  output logic [UA-1:0]               next_upc,
  output logic [UA-1:0]               upc,
  output logic [UW-1:0]               uir,
  output logic [$clog2(SDEPTH+1)-1:0] depth,
  output logic                        halted,
  output logic                        stack_err
);

  logic [UA-1:0]       upc_q;
  logic [UW-1:0]       uir_q;
  logic                stackErr_q;

  seq_op_e             seqOp;
  logic [COND_W-1:0]   cond;
  logic [UA-1:0]       target;
  logic [3:0]          flagsExt;
  logic                condTrue;
  logic [UA-1:0]       upcInc;
  logic [UA-1:0]       dispAddr;

  logic                stackPush;
  logic                stackPop;
  logic                errSet;
  logic [UA-1:0]       stackTop;
  logic                stackFull;
  logic                stackEmpty;

  assign seqOp    = seq_op_e'(uir_q[seqOpLsb(UW) +: SEQ_OP_W]);
  assign cond     = uir_q[condLsb(UW) +: COND_W];
  assign target   = uir_q[targetMsb(UA):0];
  assign upcInc   = upc_q + UA'(1);
  assign dispAddr = target + UA'(opcode);

  // Flag selects beyond NFLAG read as zero.
  always_comb begin
    flagsExt              = '0;
    flagsExt[NFLAG-1:0]   = flags;
  end

  assign condTrue = (flagsExt[cond[1:0]] == cond[2]);

  // Returning upc makes the ROM refetch the current word, which is how hold,
  // wait, halt and stack errors freeze the sequencer without extra state.
  always_comb begin
    next_upc  = upcInc;
    stackPush = 1'b0;
    stackPop  = 1'b0;
    errSet    = 1'b0;
    if (rst) begin
      next_upc = '0;
    end else if (stackErr_q || (seqOp == SEQ_HALT) || hold) begin
      next_upc = upc_q;
    end else begin
      case (seqOp)
        SEQ_NEXT:  next_upc = upcInc;
        SEQ_JMP:   next_upc = target;
        SEQ_JCOND: next_upc = condTrue ? target : upcInc;
        SEQ_CALL: begin
          if (stackFull) begin
            errSet   = 1'b1;
            next_upc = upc_q;
          end else begin
            stackPush = 1'b1;
            next_upc  = target;
          end
        end
        SEQ_RET: begin
          if (stackEmpty) begin
            errSet   = 1'b1;
            next_upc = upc_q;
          end else begin
            stackPop = 1'b1;
            next_upc = stackTop;
          end
        end
        SEQ_DISP:  next_upc = dispAddr;
        SEQ_WAIT:  next_upc = mem_ready ? upcInc : upc_q;
        default:   next_upc = upc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q      <= '1;
      uir_q      <= '0;
      stackErr_q <= 1'b0;
    end else begin
      upc_q      <= next_upc;
      uir_q      <= rom_d;
      stackErr_q <= stackErr_q | errSet;
    end
  end

  useq_stack #(
    .UA     (UA),
    .SDEPTH (SDEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (stackPush),
    .pop_i   (stackPop),
    .din_i   (upcInc),
    .top_o   (stackTop),
    .depth_o (depth),
    .full_o  (stackFull),
    .empty_o (stackEmpty)
  );

  assign upc       = upc_q;
  assign uir       = uir_q;
  assign stack_err = stackErr_q;
  assign halted    = stackErr_q | (seqOp == SEQ_HALT);

endmodule

// File: tb/tb_useq_gen.sv
// Self-checking bench for useq_gen: directed program scenarios plus random
// microcode, all compared every cycle against a queue-based sequencer model.
module tb_useq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] rom_d;
  logic [3:0]  flags;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic        hold;
  logic [7:0]  next_upc;
  logic [7:0]  upc;
  logic [23:0] uir;
  logic [2:0]  depth;
  logic        halted;
  logic        stack_err;

  logic [23:0] romMem [256];
  int          testCount = 0;
  int          failCount = 0;

  int          mUpc;
  logic [23:0] mUir;
  bit          mErr;
  int          mStack[$];

  int          upcTrace[5]   = '{'h10, 'h80, 'h90, 'h81, 'h11};
  int          depthTrace[5] = '{0, 1, 2, 1, 0};

  always #5 clk = ~clk;

  useq_gen #(
    .UA(8), .UW(24), .NFLAG(4), .SDEPTH(4), .OPW(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_d     (rom_d),
    .flags     (flags),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .hold      (hold),
    .next_upc  (next_upc),
    .upc       (upc),
    .uir       (uir),
    .depth     (depth),
    .halted    (halted),
    .stack_err (stack_err)
  );

  // ROM latches its address on the falling edge.
  always @(negedge clk) rom_d = romMem[next_upc];

  function automatic logic [23:0] mk(input int op, input int cnd, input int tgt);
    return 24'((op << 21) | (cnd << 18) | (tgt & 255));
  endfunction

  function automatic int opOf(input logic [23:0] w);
    return (int'(w) >> 21) & 7;
  endfunction

  // Reference sequencer: decides the next address from the current word.
  task automatic modelNext(output int nxt, output bit doPush, output bit doPop, output bit doErr);
    int op, pol, sel, tgt, inc;
    op  = opOf(mUir);
    pol = (int'(mUir) >> 20) & 1;
    sel = (int'(mUir) >> 18) & 3;
    tgt = int'(mUir) & 255;
    inc = (mUpc + 1) % 256;
    doPush = 0; doPop = 0; doErr = 0;
    if (rst) nxt = 0;
    else if (mErr || op == 7 || hold) nxt = mUpc;
    else begin
      case (op)
        0: nxt = inc;
        1: nxt = tgt;
        2: nxt = ((int'(flags) >> sel) & 1) == pol ? tgt : inc;
        3: if (mStack.size() == 4) begin doErr = 1; nxt = mUpc; end
           else begin doPush = 1; nxt = tgt; end
        4: if (mStack.size() == 0) begin doErr = 1; nxt = mUpc; end
           else begin doPop = 1; nxt = mStack[$]; end
        5: nxt = (tgt + int'(opcode)) % 256;
        6: nxt = mem_ready ? inc : mUpc;
        default: nxt = mUpc;
      endcase
    end
  endtask

  task automatic tick();
    int nxt;
    bit p, q, e;
    modelNext(nxt, p, q, e);
    @(posedge clk);
    if (rst) begin
      mUpc = 255; mUir = '0; mErr = 0; mStack.delete();
    end else begin
      if (p) mStack.push_back((mUpc + 1) % 256);
      if (q) void'(mStack.pop_back());
      mErr = mErr | e;
      mUpc = nxt;
      mUir = romMem[nxt];
    end
    #2;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    bit p, q, e;
    modelNext(n, p, q, e);
    checkEq({tag, "/next_upc"},  32'(next_upc),  32'(n));
    checkEq({tag, "/upc"},       32'(upc),       32'(mUpc));
    checkEq({tag, "/uir"},       32'(uir),       32'(mUir));
    checkEq({tag, "/depth"},     32'(depth),     32'(mStack.size()));
    checkEq({tag, "/stack_err"}, 32'(stack_err), 32'(mErr));
    checkEq({tag, "/halted"},    32'(halted),    32'(mErr || opOf(mUir) == 7));
  endtask

  task automatic applyStimulus(input bit r, input logic [3:0] f, input logic [3:0] o,
                               input bit m, input bit h);
    rst = r; flags = f; opcode = o; mem_ready = m; hold = h;
    #1;
  endtask

  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      checkOutput(tag);
      tick();
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) romMem[i] = '0;
  endtask

  task automatic resetDut();
    applyStimulus(1, 0, 0, 1, 0);
    tick();
    tick();
  endtask

  initial begin
    clearRom();

    // Reset and straight-line NEXT sequencing
    resetDut();
    checkOutput("reset");
    checkEq("reset next_upc", 32'(next_upc), 0);
    checkEq("reset upc", 32'(upc), 'hFF);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("seq");
      checkEq("seq next_upc", 32'(next_upc), 32'(i));
      checkEq("seq upc", 32'(upc), 32'((i + 255) % 256));
      tick();
    end

    // Conditional branch on flag 1, both polarities
    clearRom();
    romMem[0]    = mk(1, 0, 'h05);
    romMem['h05] = mk(2, 3'b101, 'h40);
    romMem['h06] = mk(2, 3'b001, 'h40);
    resetDut();
    applyStimulus(0, 0, 0, 1, 0);
    runCycles(2, "jc_pre");
    applyStimulus(0, 4'b0010, 0, 1, 0);
    checkOutput("jc_taken");
    checkEq("jcond taken", 32'(next_upc), 'h40);
    applyStimulus(0, 4'b0000, 0, 1, 0);
    checkOutput("jc_fall");
    checkEq("jcond fallthrough", 32'(next_upc), 'h06);
    tick();
    checkOutput("jc_pol0");
    checkEq("jcond pol0", 32'(next_upc), 'h40);
    tick();
    checkOutput("jc_end");

    // Nested call / return
    clearRom();
    romMem[0]    = mk(1, 0, 'h10);
    romMem['h10] = mk(3, 0, 'h80);
    romMem['h80] = mk(3, 0, 'h90);
    romMem['h90] = mk(4, 0, 0);
    romMem['h81] = mk(4, 0, 0);
    romMem['h11] = mk(7, 0, 0);
    resetDut();
    applyStimulus(0, 0, 0, 1, 0);
    runCycles(2, "call_pre");
    for (int k = 0; k < 5; k++) begin
      checkOutput("call");
      checkEq("call upc", 32'(upc), 32'(upcTrace[k]));
      checkEq("call depth", 32'(depth), 32'(depthTrace[k]));
      tick();
    end
    checkEq("halt flag", 32'(halted), 1);

    // Reset while two calls deep empties the stack
    resetDut();
    applyStimulus(0, 0, 0, 1, 0);
    runCycles(4, "midcall");
    checkEq("midcall depth", 32'(depth), 2);
    applyStimulus(1, 0, 0, 1, 0);
    tick();
    checkEq("midcall reset depth", 32'(depth), 0);
    checkOutput("midcall_rst");

    // Stack overflow on fifth nested call
    clearRom();
    romMem[0]    = mk(3, 0, 'h20);
    romMem['h20] = mk(3, 0, 'h30);
    romMem['h30] = mk(3, 0, 'h40);
    romMem['h40] = mk(3, 0, 'h50);
    romMem['h50] = mk(3, 0, 'h60);
    resetDut();
    applyStimulus(0, 0, 0, 1, 0);
    runCycles(5, "ovf_pre");
    checkEq("ovf fifth next", 32'(next_upc), 'h50);
    checkEq("ovf not yet halted", 32'(halted), 0);
    tick();
    checkOutput("ovf");
    checkEq("ovf stack_err", 32'(stack_err), 1);
    checkEq("ovf halted", 32'(halted), 1);
    checkEq("ovf depth", 32'(depth), 4);
    checkEq("ovf frozen next", 32'(next_upc), 'h50);
    runCycles(3, "ovf_hold");

    // Return with empty stack
    clearRom();
    romMem[0] = mk(4, 0, 0);
    resetDut();
    applyStimulus(0, 0, 0, 1, 0);
    runCycles(2, "unf");
    checkOutput("unf_err");
    checkEq("underflow stack_err", 32'(stack_err), 1);

    // Opcode dispatch, including wrap
    clearRom();
    romMem[0]    = mk(5, 0, 'h30);
    romMem['h3A] = mk(5, 0, 'hF8);
    resetDut();
    applyStimulus(0, 0, 4'hA, 1, 0);
    runCycles(1, "disp_pre");
    checkOutput("disp");
    checkEq("disp next", 32'(next_upc), 'h3A);
    tick();
    checkOutput("disp_wrap");
    checkEq("disp wrap next", 32'(next_upc), 'h02);
    tick();
    checkOutput("disp_end");

    // Memory wait then external hold across a jump
    clearRom();
    romMem[0]    = mk(1, 0, 'h20);
    romMem['h20] = mk(6, 0, 0);
    romMem['h21] = mk(1, 0, 'h50);
    resetDut();
    applyStimulus(0, 0, 0, 0, 0);
    runCycles(2, "wait_pre");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, k == 3, 0);
      checkOutput("wait");
      checkEq("wait upc", 32'(upc), 'h20);
      tick();
    end
    checkEq("wait release upc", 32'(upc), 'h21);
    applyStimulus(0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold");
      checkEq("hold upc", 32'(upc), 'h21);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 0);
    checkEq("hold drop next", 32'(next_upc), 'h50);
    tick();
    checkEq("hold jump upc", 32'(upc), 'h50);
    checkOutput("hold_end");

    // Random microcode and inputs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 256; i++) begin
        int op;
        op = $urandom_range(0, 7);
        if (op == 7 && $urandom_range(0, 3) != 0) op = 0;
        romMem[i] = {3'(op), 21'($urandom)};
      end
      resetDut();
      for (int c = 0; c < 60; c++) begin
        applyStimulus($urandom_range(0, 49) == 0, 4'($urandom), 4'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
        checkOutput("rand");
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
